// File: rtl/dmem_mmio_pkg.sv
// Shared address map, register offsets and TXSTAT bit layout for the
// data-memory / MMIO block.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] OFF_CYCLE   = 32'h0000_0000;
  localparam logic [31:0] OFF_TCMP    = 32'h0000_0004;
  localparam logic [31:0] OFF_TSTAT   = 32'h0000_0008;
  localparam logic [31:0] OFF_TXDATA  = 32'h0000_0010;
  localparam logic [31:0] OFF_TXSTAT  = 32'h0000_0014;

  localparam int TXSTAT_COUNT_W  = 3;
  localparam int TXSTAT_FULL_BIT = 3;
  localparam int TXSTAT_EMPTY_BIT = 4;
  localparam int TXSTAT_OVF_BIT  = 5;
  localparam int TSTAT_CLR_BIT   = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_TCMP,
    SEL_TSTAT,
    SEL_TXDATA,
    SEL_TXSTAT
  } sel_t;

  // Byte-offset bits are ignored everywhere, so decode on the word address.
  function automatic sel_t decode(input logic [31:0] addr, input int ram_aw);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    if ((word >> (ram_aw + 2)) == 32'd0) return SEL_RAM;
    case (word)
      MMIO_BASE + OFF_CYCLE:  return SEL_CYCLE;
      MMIO_BASE + OFF_TCMP:   return SEL_TCMP;
      MMIO_BASE + OFF_TSTAT:  return SEL_TSTAT;
      MMIO_BASE + OFF_TXDATA: return SEL_TXDATA;
      MMIO_BASE + OFF_TXSTAT: return SEL_TXSTAT;
      default:                return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO with an explicit occupancy count so that full and empty
// never alias; a push into a full FIFO is accepted only alongside a pop.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_en;
  logic             push_en;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// CPU data memory with a small MMIO window: free-running cycle counter,
// compare timer with sticky interrupt flag, and a TX FIFO with overflow flag.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle;
  logic [31:0]   tcmp;
  logic          irq;
  logic          overflow;
  sel_t          sel;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          irq_set;
  logic          irq_clr;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   txstat;

  assign sel       = decode(memaddr, AW);
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign fifo_push = memwrite && (sel == SEL_TXDATA);
  assign out_valid = ~fifo_empty;
  assign timer_irq = irq;

  assign irq_set = (tcmp != 32'd0) && (cycle == tcmp);
  assign irq_clr = memwrite && (sel == SEL_TSTAT) && memwritedata[TSTAT_CLR_BIT];
  assign ovf_set = fifo_push & fifo_full & ~fifo_pop;
  assign ovf_clr = memwrite && (sel == SEL_TXSTAT) && memwritedata[TXSTAT_OVF_BIT];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32),
    .CW    (CW)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (memwritedata),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (out_data)
  );

  // RAM contents survive reset, but a store in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!reset && memwrite && (sel == SEL_RAM)) ram[memaddr[AW+1:2]] <= memwritedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle    <= '0;
      tcmp     <= '0;
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (memwrite && (sel == SEL_TCMP)) tcmp <= memwritedata;
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    txstat = '0;
    txstat[TXSTAT_COUNT_W-1:0] = TXSTAT_COUNT_W'(fifo_count);
    txstat[TXSTAT_FULL_BIT]    = fifo_full;
    txstat[TXSTAT_EMPTY_BIT]   = fifo_empty;
    txstat[TXSTAT_OVF_BIT]     = overflow;
  end

  always_comb begin
    memreaddata = '0;
    case (sel)
      SEL_RAM:    memreaddata = ram[memaddr[AW+1:2]];
      SEL_CYCLE:  memreaddata = cycle;
      SEL_TCMP:   memreaddata = tcmp;
      SEL_TSTAT:  memreaddata = {31'b0, irq};
      SEL_TXSTAT: memreaddata = txstat;
      default:    memreaddata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios with literal expectations, then
// random traffic compared each cycle against a behavioural model.
module tb_dmem_mmio;

  localparam int RAM_WORDS  = 256;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
  localparam logic [31:0] A_TSTAT  = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0] m_ram [RAM_WORDS];
  bit        m_known [RAM_WORDS];
  bit [31:0] m_cycle;
  bit [31:0] m_tcmp;
  bit        m_irq;
  bit        m_ovf;
  bit [31:0] m_fifo [$];

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .timer_irq    (timer_irq)
  );

  function automatic bit [31:0] model_txstat();
    bit [31:0] s;
    s = m_fifo.size();
    if (m_fifo.size() == FIFO_DEPTH) s = s + 32'h08;
    if (m_fifo.size() == 0)          s = s + 32'h10;
    if (m_ovf)                       s = s + 32'h20;
    return s;
  endfunction

  function automatic bit [31:0] model_read(input bit [31:0] a, output bit known);
    bit [31:0] w;
    w = a & 32'hFFFF_FFFC;
    known = 1'b1;
    if (w < RAM_WORDS * 4) begin
      known = m_known[w / 4];
      return m_ram[w / 4];
    end
    if (w == A_CYCLE)  return m_cycle;
    if (w == A_TCMP)   return m_tcmp;
    if (w == A_TSTAT)  return {31'b0, m_irq};
    if (w == A_TXSTAT) return model_txstat();
    return 32'd0;
  endfunction

  // Advances the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit [31:0] w;
    bit        pop;
    bit        irq_set;
    bit        ovf_set;
    if (reset) begin
      m_cycle = 0;
      m_tcmp  = 0;
      m_irq   = 0;
      m_ovf   = 0;
      m_fifo.delete();
      return;
    end
    w       = memaddr & 32'hFFFF_FFFC;
    pop     = (m_fifo.size() > 0) && out_ready;
    irq_set = (m_tcmp != 0) && (m_cycle == m_tcmp);
    ovf_set = 0;
    if (pop) void'(m_fifo.pop_front());
    if (memwrite) begin
      if (w < RAM_WORDS * 4) begin
        m_ram[w / 4]   = memwritedata;
        m_known[w / 4] = 1'b1;
      end else if (w == A_TCMP) begin
        m_tcmp = memwritedata;
      end else if (w == A_TSTAT) begin
        if (memwritedata[0]) m_irq = 0;
      end else if (w == A_TXSTAT) begin
        if (memwritedata[5]) m_ovf = 0;
      end else if (w == A_TXDATA) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(memwritedata);
        else ovf_set = 1;
      end
    end
    if (irq_set) m_irq = 1;
    if (ovf_set) m_ovf = 1;
    m_cycle = m_cycle + 1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit [31:0] exp_rd;
    bit        known;
    exp_rd = model_read(memaddr, known);
    if (known) check_val("memreaddata", memreaddata, exp_rd);
    check_val("timer_irq", {31'b0, timer_irq}, {31'b0, m_irq});
    check_val("out_valid", {31'b0, out_valid}, {31'b0, m_fifo.size() > 0});
    if (m_fifo.size() > 0) check_val("out_data", out_data, m_fifo[0]);
  endtask

  task automatic applyStimulus(input bit rst, input bit we, input bit [31:0] addr,
                               input bit [31:0] data, input bit rdy,
                               input bit lit_en, input bit [31:0] lit);
    reset        = rst;
    memwrite     = we;
    memaddr      = addr;
    memwritedata = data;
    out_ready    = rdy;
    @(negedge clk);
    checkOutput();
    if (lit_en) check_val("literal_read", memreaddata, lit);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    bit [31:0] a;
    bit [31:0] d;
    int        r;
    reset = 1'b1; memwrite = 1'b0; memaddr = '0; memwritedata = '0; out_ready = 1'b0;
    @(posedge clk);
    model_step();
    #1;

    // Reset state
    check_val("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("reset_irq", {31'b0, timer_irq}, 32'd0);
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h10);
    applyStimulus(0, 0, A_TCMP, 0, 0, 1, 32'h0);

    // Store then load; same-cycle load sees the old word
    applyStimulus(0, 1, 32'h10, 32'h1111_1111, 0, 0, 0);
    applyStimulus(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 1, 32'h1111_1111);
    applyStimulus(0, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 32'h13, 0, 0, 1, 32'hDEAD_BEEF);

    // Cycle counter after reset and 10 idle cycles
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, A_CYCLE, 32'h5555, 0, 1, 32'd10);
    applyStimulus(0, 0, A_CYCLE, 0, 0, 1, 32'd11);

    // Timer compare and flag clear
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, A_TCMP, 32'd20, 0, 0, 0);
    for (int k = 1; k < 20; k++) applyStimulus(0, 0, A_CYCLE, 0, 0, 1, k);
    check_val("irq_before_match", {31'b0, timer_irq}, 32'd0);
    applyStimulus(0, 0, A_CYCLE, 0, 0, 1, 32'd20);
    check_val("irq_after_match", {31'b0, timer_irq}, 32'd1);
    applyStimulus(0, 0, A_TSTAT, 0, 0, 1, 32'd1);
    applyStimulus(0, 1, A_TSTAT, 32'd1, 0, 0, 0);
    check_val("irq_after_clear", {31'b0, timer_irq}, 32'd0);

    // Overflow when full with no consumer, then in-order drain
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, A_TXDATA, i, 0, 0, 0);
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h2C);
    applyStimulus(0, 0, A_TXDATA, 0, 0, 1, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check_val("drain_data", out_data, i);
      applyStimulus(0, 0, A_TXSTAT, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h30);
    applyStimulus(0, 1, A_TXSTAT, 32'h20, 0, 0, 0);
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h10);

    // Push into a full FIFO alongside a pop is accepted
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, A_TXDATA, i, 0, 0, 0);
    applyStimulus(0, 1, A_TXDATA, 32'd9, 1, 0, 0);
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h0C);
    for (int i = 0; i < 4; i++) begin
      check_val("full_push_pop_data", out_data, (i == 3) ? 32'd9 : i + 2);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h10);

    // Unmapped addresses read zero and ignore stores
    applyStimulus(0, 1, 32'h0, 32'hA5A5_0001, 0, 0, 0);
    applyStimulus(0, 0, 32'h0000_8000, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 32'hFFFF_0020, 0, 0, 1, 32'h0);
    applyStimulus(0, 1, 32'h0000_8000, 32'h1234_5678, 0, 0, 0);
    applyStimulus(0, 1, 32'hFFFF_0020, 32'h8765_4321, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_0400, 32'h0BAD_0BAD, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hA5A5_0001);
    applyStimulus(0, 0, 32'h0000_8000, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, A_TXSTAT, 0, 0, 1, 32'h10);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      a = ($urandom_range(0, RAM_WORDS - 1) << 2) | ($urandom & 3);
      else if (r < 48) a = A_CYCLE;
      else if (r < 56) a = A_TCMP;
      else if (r < 64) a = A_TSTAT;
      else if (r < 82) a = A_TXDATA;
      else if (r < 92) a = A_TXSTAT;
      else case ($urandom_range(0, 3))
        0:       a = 32'h0000_8000;
        1:       a = 32'hFFFF_0020;
        2:       a = 32'h0000_0400;
        default: a = 32'hFFFF_000C;
      endcase
      d = $urandom;
      if (a == A_TCMP) d = m_cycle + $urandom_range(2, 30);
      if (a == A_TSTAT || a == A_TXSTAT) d = ($urandom_range(0, 1) == 1) ? 32'h21 : 32'h0;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 45, a, d,
                    $urandom_range(0, 99) < 40, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
